// File: rtl/arb4_rr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arb4_rr_ctrl
//  Description : Round-robin arbiter / packet sequencer for a shared 4:1
//                datapath mux. Owns the mux select, holds it for a whole
//                packet (or a MAX_BURST slice of it) and generates the
//                per-requester ready plus downstream valid/last.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb4_rr_ctrl #(
    parameter int MAX_BURST = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_valid,
    input  logic [3:0] req_last,
    output logic [3:0] req_ready,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic       busy
);

    // Beat counter is wide enough to hold the value MAX_BURST itself.
    localparam int                 CNT_W       = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   C_MAX_BEATS = CNT_W'(MAX_BURST);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q,   sel_d;
    logic [1:0]       prio_q,  prio_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // ------------------------------------------------------------------
    // Winner selection: requests rotated so that bit 0 is the requester
    // currently holding highest priority; the lowest set rotated bit wins.
    // ------------------------------------------------------------------
    logic [3:0] w_rot;
    logic [1:0] w_win_off;
    logic [1:0] w_winner;

    for (genvar k = 0; k < 4; k++) begin : g_rot
        assign w_rot[k] = req_valid[prio_q + 2'(k)];
    end

    // Priority-encode the rotated request vector (lowest index first).
    always_comb begin
        w_win_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_win_off = 2'(k);
            end
        end
    end

    assign w_winner = prio_q + w_win_off;

    // ------------------------------------------------------------------
    // Beat accounting while granted.
    // ------------------------------------------------------------------
    logic             w_beat_acc;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_burst_done;
    logic             w_rel_now;

    assign w_beat_acc   = (state_q == ST_GRANT) & req_valid[sel_q] & out_ready;
    assign w_cnt_inc    = (cnt_q == C_MAX_BEATS) ? cnt_q : (cnt_q + CNT_W'(1));
    // Forced release happens on the accept that brings the count to the limit;
    // it never touches out_last, the requester simply resumes on its next grant.
    assign w_burst_done = (w_cnt_inc == C_MAX_BEATS);
    assign w_rel_now    = w_beat_acc & (req_last[sel_q] | w_burst_done);

    // State register: synchronous active-low reset aborts any grant in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            prio_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and handshake outputs; select only moves on IDLE->GRANT.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        req_ready = 4'b0000;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d = ST_GRANT;
                    sel_d   = w_winner;
                    cnt_d   = '0;
                end
            end

            ST_GRANT: begin
                busy             = 1'b1;
                out_valid        = req_valid[sel_q];
                out_last         = req_last[sel_q];
                req_ready[sel_q] = out_ready;
                if (w_beat_acc) begin
                    cnt_d = w_cnt_inc;
                    if (w_rel_now) begin
                        state_d = ST_IDLE;
                        prio_d  = sel_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel = sel_q;

`ifndef SYNTHESIS
    // Simulation-only sanity properties on the mux select and ready vector.
    a_sel_known : assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(sel));
    a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
`endif

endmodule
`default_nettype wire

// File: tb/tb_arb4_rr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb4_rr_ctrl
//  Description : Self-checking bench for arb4_rr_ctrl. Reactive requester
//                model plus a scoreboard of expected {sel,last} per accepted
//                beat. Instance A uses MAX_BURST=16, instance B MAX_BURST=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb4_rr_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_last;
    logic       out_ready;

    logic [3:0] a_rr,   b_rr;
    logic       a_ov,   b_ov;
    logic       a_ol,   b_ol;
    logic [1:0] a_sel,  b_sel;
    logic       a_busy, b_busy;

    arb4_rr_ctrl u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (a_rr),
        .out_valid (a_ov),
        .out_last  (a_ol),
        .out_ready (out_ready),
        .sel       (a_sel),
        .busy      (a_busy)
    );

    arb4_rr_ctrl #(.MAX_BURST(4)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (b_rr),
        .out_valid (b_ov),
        .out_last  (b_ol),
        .out_ready (out_ready),
        .sel       (b_sel),
        .busy      (b_busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Requester model: beats left overall, packet length, index in packet.
    int total [4];
    int plen  [4];
    int bidx  [4];

    logic       use_b = 1'b0;
    logic [2:0] sb [$];          // expected {sel, last} per accepted beat
    int         cyc = 0;
    int         acc_cyc [$];
    int         acc_who [$];

    // Values observed at the negedge of the most recent step.
    logic [3:0] s_rr;
    logic       s_busy;
    logic [1:0] s_sel;

    // Scoreboard monitor on the selected instance.
    logic       m_ov, m_ol;
    logic [1:0] m_sel;
    logic [2:0] m_exp;
    always @(negedge clk) begin
        m_ov  = use_b ? b_ov  : a_ov;
        m_ol  = use_b ? b_ol  : a_ol;
        m_sel = use_b ? b_sel : a_sel;
        if (m_ov === 1'b1 && out_ready === 1'b1) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected_accept: got sel=%0d last=%0d, required no accept", m_sel, m_ol);
            end else begin
                m_exp = sb.pop_front();
                if ({m_sel, m_ol} !== m_exp) begin
                    tests_failed++;
                    $display("FAIL sb_beat: got sel=%0d last=%0d, required sel=%0d last=%0d",
                             m_sel, m_ol, m_exp[2:1], m_exp[0]);
                end
            end
        end
    end

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = (total[i] > 0);
            req_last[i]  = (bidx[i] == plen[i] - 1);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            total[i] = 0;
            plen[i]  = 1;
            bidx[i]  = 0;
        end
        acc_cyc.delete();
        acc_who.delete();
    endtask

    // One clock: sample at negedge, advance the model, drive after posedge.
    task automatic step();
        logic [3:0] acc;
        @(negedge clk);
        s_rr   = use_b ? b_rr   : a_rr;
        s_busy = use_b ? b_busy : a_busy;
        s_sel  = use_b ? b_sel  : a_sel;
        acc    = s_rr & req_valid;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                acc_cyc.push_back(cyc);
                acc_who.push_back(i);
                total[i]--;
                bidx[i]++;
                if (bidx[i] == plen[i]) bidx[i] = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    task automatic run_drain(input int budget, output bit timed_out);
        int n;
        n = 0;
        while ((total[0] + total[1] + total[2] + total[3] > 0 || sb.size() > 0) && n < budget) begin
            step();
            n++;
        end
        timed_out = (n >= budget);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        clear_model();
        drive_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit to;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clear_model();
        for (int i = 0; i < 4; i++) total[i] = 1;
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++;
            if (s_busy !== 1'b0 || s_sel !== 2'd0 || s_rr !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_hold: got busy=%b sel=%0d rdy=%b, required busy=0 sel=0 rdy=0000",
                         s_busy, s_sel, s_rr);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back({2'(i), 1'b1});
        step();
        tests_run++;
        if (s_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got busy=%b, required 0", s_busy);
        end
        step();
        tests_run++;
        if (s_busy !== 1'b1 || s_sel !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_first_grant: got busy=%b sel=%0d, required busy=1 sel=0", s_busy, s_sel);
        end
        run_drain(100, to);
        tests_run++;
        if (to || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    task automatic test_fairness();
        bit to;
        clear_model();
        for (int i = 0; i < 4; i++) total[i] = 2;
        for (int k = 0; k < 8; k++) sb.push_back({2'(k % 4), 1'b1});
        drive_inputs();
        run_drain(100, to);
        tests_run++;
        if (to || acc_who.size() != 8) begin
            tests_failed++;
            $display("FAIL fair_count: got %0d accepts, required 8", acc_who.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                tests_run++;
                if (acc_who[k] !== k % 4 || (k > 0 && acc_cyc[k] - acc_cyc[k-1] != 2)) begin
                    tests_failed++;
                    $display("FAIL fair_order: beat %0d got req=%0d gap=%0d, required req=%0d gap=2",
                             k, acc_who[k], (k > 0) ? acc_cyc[k] - acc_cyc[k-1] : 2, k % 4);
                end
            end
        end
    endtask

    task automatic test_multibeat_lock();
        bit to;
        int exp_who, exp_gap;
        clear_model();
        total[1] = 1;                       // moves priority pointer to 2
        sb.push_back({2'd1, 1'b1});
        drive_inputs();
        run_drain(50, to);
        clear_model();
        total[2] = 5; plen[2] = 5;
        total[1] = 1; plen[1] = 1;
        for (int k = 0; k < 5; k++) sb.push_back({2'd2, (k == 4)});
        sb.push_back({2'd1, 1'b1});
        drive_inputs();
        run_drain(100, to);
        tests_run++;
        if (to || acc_who.size() != 6) begin
            tests_failed++;
            $display("FAIL lock_count: got %0d accepts, required 6", acc_who.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                exp_who = (k < 5) ? 2 : 1;
                exp_gap = (k == 5) ? 2 : 1;
                tests_run++;
                if (acc_who[k] !== exp_who || (k > 0 && acc_cyc[k] - acc_cyc[k-1] != exp_gap)) begin
                    tests_failed++;
                    $display("FAIL lock_seq: beat %0d got req=%0d, required req=%0d gap=%0d",
                             k, acc_who[k], exp_who, exp_gap);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit   done, last_seen;
        logic ordy_now;
        int   nb;
        clear_model();
        total[3] = 3; plen[3] = 3;
        sb.push_back({2'd3, 1'b0});
        sb.push_back({2'd3, 1'b0});
        sb.push_back({2'd3, 1'b1});
        out_ready = 1'b1;
        drive_inputs();
        done = 1'b0;
        last_seen = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            ordy_now = out_ready;
            nb = acc_who.size();
            step();
            if (last_seen) begin
                tests_run++;
                if (s_busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bp_release: got busy=%b, required 0", s_busy);
                end
                done = 1'b1;
            end else if (s_busy === 1'b1) begin
                tests_run++;
                if (s_rr !== {ordy_now, 3'b000} || s_sel !== 2'd3) begin
                    tests_failed++;
                    $display("FAIL bp_ready: got rdy=%b sel=%0d, required rdy=%b sel=3",
                             s_rr, s_sel, {ordy_now, 3'b000});
                end
                if (acc_who.size() == 3 && nb == 2) last_seen = 1'b1;
                out_ready = ~out_ready;
            end
        end
        tests_run++;
        if (!done || acc_who.size() != 3 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_accepts: got %0d accepts, required 3", acc_who.size());
        end
        out_ready = 1'b1;
    endtask

    task automatic test_burst_limit();
        bit to;
        int exp_gap;
        use_b = 1'b1;
        reset_pulse();
        total[1] = 10; plen[1] = 10;
        for (int k = 1; k <= 10; k++) sb.push_back({2'd1, (k == 10)});
        drive_inputs();
        run_drain(100, to);
        tests_run++;
        if (to || acc_who.size() != 10) begin
            tests_failed++;
            $display("FAIL burst_count: got %0d accepts, required 10", acc_who.size());
        end else begin
            for (int k = 1; k < 10; k++) begin
                exp_gap = (k == 4 || k == 8) ? 2 : 1;
                tests_run++;
                if (acc_cyc[k] - acc_cyc[k-1] != exp_gap) begin
                    tests_failed++;
                    $display("FAIL burst_gap: before beat %0d got gap=%0d, required %0d",
                             k + 1, acc_cyc[k] - acc_cyc[k-1], exp_gap);
                end
            end
        end
        use_b = 1'b0;
    endtask

    task automatic test_wrap_midreset();
        bit to;
        reset_pulse();
        total[3] = 1;
        sb.push_back({2'd3, 1'b1});
        drive_inputs();
        run_drain(50, to);
        clear_model();
        total[0] = 4; plen[0] = 4;
        total[3] = 1; plen[3] = 1;
        sb.push_back({2'd0, 1'b0});
        sb.push_back({2'd0, 1'b0});
        drive_inputs();
        for (int k = 0; k < 40 && acc_who.size() < 2; k++) step();
        tests_run++;
        if (acc_who.size() != 2 || acc_who[0] !== 0) begin
            tests_failed++;
            $display("FAIL wrap_grant: got %0d accepts first req=%0d, required 2 accepts from req 0",
                     acc_who.size(), (acc_who.size() > 0) ? acc_who[0] : -1);
        end
        rst_n     = 1'b0;
        out_ready = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        tests_run++;
        if (s_busy !== 1'b0 || s_sel !== 2'd0 || s_rr !== 4'b0000 || acc_who.size() != 2) begin
            tests_failed++;
            $display("FAIL midreset: got busy=%b sel=%0d rdy=%b accepts=%0d, required busy=0 sel=0 rdy=0000 accepts=2",
                     s_busy, s_sel, s_rr, acc_who.size());
        end
        reset_pulse();
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_multibeat_lock();
        test_backpressure();
        test_burst_limit();
        test_wrap_midreset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
